// File: rtl/q_add_if.sv
// Operand/result bundle for the sign-magnitude Q-format adder.
// in_valid qualifies add1/add2 for one cycle; out_valid qualifies sum/overflow for one cycle; no backpressure.
interface q_add_if #(
    parameter int N = 32
);
    logic         in_valid;
    logic [N-1:0] add1;
    logic [N-1:0] add2;
    logic [N-1:0] sum;
    logic         overflow;
    logic         out_valid;

    modport master (
        output in_valid, add1, add2,
        input  sum, overflow, out_valid
    );

    modport slave (
        input  in_valid, add1, add2,
        output sum, overflow, out_valid
    );
endinterface

// File: rtl/q_add.sv
// Registered sign-magnitude fixed-point adder: combinational add/subtract of the
// magnitudes followed by a single output register stage (latency 1, throughput 1).
module q_add #(
    parameter int N = 32,
    parameter int Q = 15
) (
    input  logic    clk,
    input  logic    rst,
    q_add_if.slave  bus
);
    // Q only marks the binary point; reject a point that falls outside the magnitude field.
    if (Q < 0 || Q > N - 1) begin : g_bad_q
        $error("q_add: Q must lie within the magnitude field");
    end

    logic         sign_a;
    logic         sign_b;
    logic [N-2:0] mag_a;
    logic [N-2:0] mag_b;
    logic [N-1:0] mag_sum;
    logic [N-2:0] res_mag;
    logic         res_sign;
    logic         res_ovf;

    assign sign_a  = bus.add1[N-1];
    assign sign_b  = bus.add2[N-1];
    assign mag_a   = bus.add1[N-2:0];
    assign mag_b   = bus.add2[N-2:0];
    assign mag_sum = {1'b0, mag_a} + {1'b0, mag_b};

    always_comb begin
        res_mag  = '0;
        res_sign = 1'b0;
        res_ovf  = 1'b0;
        if (sign_a == sign_b) begin
            res_mag  = mag_sum[N-2:0];
            res_ovf  = mag_sum[N-1];
            res_sign = sign_a;
        end else if (mag_a > mag_b) begin
            res_mag  = mag_a - mag_b;
            res_sign = sign_a;
        end else if (mag_b > mag_a) begin
            res_mag  = mag_b - mag_a;
            res_sign = sign_b;
        end
        // A zero magnitude is always emitted as +0, including -0 + -0 and a wrap to zero.
        if (res_mag == '0) begin
            res_sign = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.sum       <= '0;
            bus.overflow  <= 1'b0;
            bus.out_valid <= 1'b0;
        end else begin
            bus.out_valid <= bus.in_valid;
            if (bus.in_valid) begin
                bus.sum      <= {res_sign, res_mag};
                bus.overflow <= res_ovf;
            end
        end
    end
endmodule

// File: tb/tb_q_add.sv
// Self-checking bench for q_add: directed test-plan vectors, hold/reset control cases,
// then randomized traffic scored against a signed-integer reference model.
module tb_q_add;
    localparam int N = 32;

    logic clk;
    logic rst;

    q_add_if #(.N(N)) bus ();

    q_add #(.N(N), .Q(15)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // {overflow, sum}
    logic [N:0] exp_q[$];
    logic [N:0] last_res;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Reference: treat operands as signed integers, add, then re-encode as sign-magnitude.
    function automatic logic [N:0] model(input logic [N-1:0] a, input logic [N-1:0] b);
        longint va;
        longint vb;
        longint t;
        longint m;
        longint lim;
        logic   ov;
        logic   s;
        lim = longint'(1) << (N - 1);
        va = longint'(a[N-2:0]);
        vb = longint'(b[N-2:0]);
        if (a[N-1]) va = -va;
        if (b[N-1]) vb = -vb;
        t  = va + vb;
        m  = (t < 0) ? -t : t;
        ov = (m >= lim);
        m  = m % lim;
        s  = (t < 0) && (m != 0);
        return {ov, s, m[N-2:0]};
    endfunction

    // driver: present one cycle of stimulus, then check the registered outputs after the edge
    task automatic step(input logic [N-1:0] a, input logic [N-1:0] b, input logic v, input logic r);
        logic [N:0] e;
        rst          = r;
        bus.in_valid = v;
        bus.add1     = a;
        bus.add2     = b;
        @(posedge clk);
        if (v && !r) exp_q.push_back(model(a, b));
        #1;
        if (r) begin
            check("rst_valid", 64'(bus.out_valid), 64'd0);
            check("rst_sum",   64'(bus.sum),       64'd0);
            check("rst_ovf",   64'(bus.overflow),  64'd0);
            last_res = '0;
        end else if (v) begin
            check("valid", 64'(bus.out_valid), 64'd1);
            if (exp_q.size() == 0) begin
                check("queue_underflow", 64'd1, 64'd0);
            end else begin
                e = exp_q.pop_front();
                check("sum", 64'(bus.sum),      64'(e[N-1:0]));
                check("ovf", 64'(bus.overflow), 64'(e[N]));
                last_res = e;
            end
        end else begin
            check("idle_valid", 64'(bus.out_valid), 64'd0);
            check("hold_sum",   64'(bus.sum),       64'(last_res[N-1:0]));
            check("hold_ovf",   64'(bus.overflow),  64'(last_res[N]));
        end
    endtask

    function automatic logic [N-1:0] rand_operand();
        logic [N-1:0] x;
        x = $urandom;
        case ($urandom_range(0, 5))
            0: x[N-2:0] = '0;
            1: x[N-2:0] = N'($urandom_range(0, 15));
            2: x[N-2:N-3] = 2'b11;
            default: ;
        endcase
        return x;
    endfunction

    logic [N-1:0] vec_a[5] = '{32'h0000000F, 32'h8000000F, 32'h8000000F, 32'hC010000F, 32'hC000000F};
    logic [N-1:0] vec_b[5] = '{32'h0000000F, 32'h0000000F, 32'h8000000F, 32'h80F00000, 32'hC0000000};
    logic [N:0]   vec_e[5] = '{33'h00000001E, 33'h000000000, 33'h08000001E, 33'h0C100000F, 33'h18000000F};

    initial begin
        logic [N-1:0] a;
        logic [N-1:0] b;
        logic [N:0]   e;
        rst          = 1'b1;
        bus.in_valid = 1'b0;
        bus.add1     = '0;
        bus.add2     = '0;
        last_res     = '0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_sum",   64'(bus.sum),       64'd0);
        check("reset_ovf",   64'(bus.overflow),  64'd0);
        check("reset_valid", 64'(bus.out_valid), 64'd0);

        // test-plan vectors, streamed back-to-back; the model must agree with the documented answers
        for (int i = 0; i < 5; i++) begin
            e = model(vec_a[i], vec_b[i]);
            check("model_vs_plan", 64'(e), 64'(vec_e[i]));
            step(vec_a[i], vec_b[i], 1'b1, 1'b0);
            check("plan_sum", 64'(bus.sum), 64'(vec_e[i][N-1:0]));
        end
        step(32'h00000005, 32'h80000008, 1'b1, 1'b0);
        check("mixed_b_larger", 64'(bus.sum), 64'h80000003);

        // drop in_valid: outputs hold
        step(32'h12345678, 32'h00000001, 1'b0, 1'b0);
        step(32'h00000000, 32'h00000000, 1'b0, 1'b0);

        // negative zero plus positive
        step(32'h80000000, 32'h00000005, 1'b1, 1'b0);
        check("negzero_plus5", 64'(bus.sum), 64'h00000005);

        // reset together with a valid transaction drops it
        step(32'h0000000F, 32'h0000000F, 1'b1, 1'b1);
        step(32'h0000000F, 32'h0000000F, 1'b0, 1'b0);

        // randomized traffic with occasional idles and resets
        for (int i = 0; i < 400; i++) begin
            a = rand_operand();
            b = rand_operand();
            if ($urandom_range(0, 7) == 0) begin
                b = {~a[N-1], a[N-2:0]};
            end
            step(a, b, ($urandom_range(0, 4) != 0), ($urandom_range(0, 40) == 0));
        end

        step('0, '0, 1'b0, 1'b0);
        check("queue_empty", 64'(exp_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
